// File: rtl/autobaud_detect.sv
// ============================================================================
// Module  : autobaud_detect
// Purpose : Measures a 0x55 sync character on RX and picks the nearest baud_sel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module autobaud_detect #(
    parameter int          MEAS_W      = 17,
    parameter logic [3:0]  DEFAULT_SEL = 4'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic [3:0]  baud_sel,
    output logic [11:0] meas_div
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_MEASURE = 3'd2,
        S_SEARCH  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_sync1;
    logic                r_sync2;
    logic                r_rx_prev;
    logic [MEAS_W-1:0]   r_cnt;
    logic [2:0]          r_edges;
    logic [3:0]          r_idx;
    logic [11:0]         r_meas;
    logic [3:0]          r_sel;
    logic [3:0]          r_best_sel;
    logic [11:0]         r_best_div;
    logic [11:0]         r_best_err;
    logic                r_valid;
    logic                r_ok;

    logic                w_fall;
    logic                w_e5;
    logic                w_tmo;
    logic [MEAS_W+1:0]   w_sum;
    logic [MEAS_W+1:0]   w_q;
    logic [11:0]         w_meas;
    logic [11:0]         w_div;
    logic [11:0]         w_err;
    logic                w_ok;

    function automatic logic [11:0] div_of(input logic [3:0] sel);
        case (sel)
            4'd0:    div_of = 12'd1302;
            4'd1:    div_of = 12'd217;
            4'd2:    div_of = 12'd108;
            4'd3:    div_of = 12'd54;
            4'd4:    div_of = 12'd27;
            4'd5:    div_of = 12'd22;
            4'd6:    div_of = 12'd20;
            4'd7:    div_of = 12'd19;
            4'd8:    div_of = 12'd16;
            4'd9:    div_of = 12'd15;
            4'd10:   div_of = 12'd10;
            4'd11:   div_of = 12'd8;
            4'd12:   div_of = 12'd6;
            4'd13:   div_of = 12'd5;
            4'd14:   div_of = 12'd4;
            default: div_of = 12'd2;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall = r_rx_prev & ~r_sync2;
    assign w_e5   = (r_state == S_MEASURE) && w_fall && (r_edges == 3'd4);
    assign w_tmo  = (r_state == S_MEASURE) && !w_e5 && (r_cnt == {MEAS_W{1'b1}});

    // r_cnt lags the E1..E5 distance by one, so T+16 = r_cnt+17
    assign w_sum  = (MEAS_W+2)'(r_cnt) + (MEAS_W+2)'(17);
    assign w_q    = w_sum >> 5;
    assign w_meas = (w_q > (MEAS_W+2)'(4095)) ? 12'hFFF : w_q[11:0];

    assign w_div  = div_of(r_idx);
    assign w_err  = (r_meas >= w_div) ? (r_meas - w_div) : (w_div - r_meas);
    assign w_ok   = r_valid && ({1'b0, r_best_err, 3'b000} <= {4'b0000, r_best_div});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_ARM;
            S_ARM:     if (w_fall) w_next = S_MEASURE;
            S_MEASURE: begin
                if (w_e5) begin
                    w_next = S_SEARCH;
                end else if (w_tmo) begin
                    w_next = S_DONE;
                end
            end
            S_SEARCH:  if (r_idx == 4'd15) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_edges    <= 3'd0;
            r_idx      <= 4'd0;
            r_meas     <= 12'd0;
            r_sel      <= DEFAULT_SEL;
            r_best_sel <= 4'd0;
            r_best_div <= 12'd0;
            r_best_err <= 12'd0;
            r_valid    <= 1'b0;
            r_ok       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ok    <= 1'b0;
                        r_valid <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (w_fall) begin
                        r_cnt   <= '0;
                        r_edges <= 3'd1;
                    end
                end
                S_MEASURE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_fall) r_edges <= r_edges + 1'b1;
                    if (w_e5) begin
                        r_meas     <= w_meas;
                        r_idx      <= 4'd0;
                        r_best_err <= 12'hFFF;
                        r_valid    <= 1'b1;
                    end
                end
                S_SEARCH: begin
                    r_idx <= r_idx + 1'b1;
                    // strict compare keeps the lower sel on a tie
                    if (w_err < r_best_err) begin
                        r_best_err <= w_err;
                        r_best_div <= w_div;
                        r_best_sel <= r_idx;
                    end
                end
                S_DONE: begin
                    r_ok <= w_ok;
                    if (w_ok) r_sel <= r_best_sel;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign ok       = done ? w_ok : r_ok;
    assign baud_sel = r_sel;
    assign meas_div = r_meas;

endmodule

`default_nettype wire

// File: tb/tb_autobaud_detect.sv
// ============================================================================
// Module  : tb_autobaud_detect
// Purpose : Self-checking bench for autobaud_detect (scoreboard + vector table).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_autobaud_detect;

    typedef struct {
        int period;
        int meas;
        int ok;
        int sel;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx;
    logic        start;
    logic        busy;
    logic        done;
    logic        ok;
    logic [3:0]  baud_sel;
    logic [11:0] meas_div;

    logic        rx2;
    logic        start2;
    logic        busy2;
    logic        done2;
    logic        ok2;
    logic [3:0]  baud_sel2;
    logic [11:0] meas_div2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_e1 = 0;
    int last_e5 = 0;

    exp_t sb_q[$];
    exp_t cur;
    exp_t tbl[6];
    int   sel_pending = 0;
    int   sel_expect  = 0;

    int d2_seen = 0;
    int d2_cyc  = 0;
    int d2_meas = 0;
    int d2_ok   = 0;
    int d2_busy = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    autobaud_detect u_dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .ok       (ok),
        .baud_sel (baud_sel),
        .meas_div (meas_div)
    );

    // Narrow counter so the timeout path is reachable in a short run
    autobaud_detect #(.MEAS_W(12)) u_tmo (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx2),
        .start    (start2),
        .busy     (busy2),
        .done     (done2),
        .ok       (ok2),
        .baud_sel (baud_sel2),
        .meas_div (meas_div2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (sel_pending != 0) begin
            check("baud_sel_after_done", int'(baud_sel), sel_expect);
            check("busy_after_done", int'(busy), 0);
            sel_pending = 0;
        end
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                cur = sb_q.pop_front();
                check("done_latency", cyc - last_e5, 19);
                check("busy_at_done", int'(busy), 1);
                check("meas_div", int'(meas_div), cur.meas);
                check("ok", int'(ok), cur.ok);
                sel_expect  = cur.sel;
                sel_pending = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (done2) begin
            d2_seen++;
            d2_cyc  = cyc;
            d2_meas = int'(meas_div2);
            d2_ok   = int'(ok2);
            d2_busy = int'(busy2);
        end
    end

    task automatic drive_rx(input int which, input logic v);
        if (which == 0) rx = v;
        else            rx2 = v;
    endtask

    task automatic pulse_start(input int which);
        @(posedge clock); #1;
        if (which == 0) start = 1'b1;
        else            start2 = 1'b1;
        @(posedge clock); #1;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Frame bit i of 0x55 (start, LSB-first data) is simply i%2
    task automatic send_bits(input int which, input int period, input int nbits, input int last_hold);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clock); #1;
            drive_rx(which, logic'(i % 2));
            if (i == 0) last_e1 = cyc;
            if (i == 8) last_e5 = cyc;
            repeat (((i == nbits - 1) ? last_hold : period) - 1) @(posedge clock);
        end
    endtask

    task automatic run_case(input exp_t e);
        pulse_start(0);
        sb_q.push_back(e);
        send_bits(0, e.period, 9, 30);
        @(posedge clock); #1;
        rx = 1'b1;
        for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clock);
        check("scoreboard_drained", sb_q.size(), 0);
        sb_q.delete();
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int bad;
        reset  = 1'b1;
        rx     = 1'b1;
        rx2    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        tbl[0] = '{5208, 1302, 1, 0};
        tbl[1] = '{88,   22,   1, 5};
        tbl[2] = '{82,   21,   1, 5};
        tbl[3] = '{1000, 250,  0, 5};
        tbl[4] = '{432,  108,  1, 2};
        tbl[5] = '{60,   15,   1, 9};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ok", int'(ok), 0);
        check("rst_meas_div", int'(meas_div), 0);
        check("rst_baud_sel", int'(baud_sel), 0);

        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (busy || done || ok || meas_div != 12'd0 || baud_sel != 4'd0) bad++;
        end
        check("idle_quiet", bad, 0);

        for (int t = 0; t < 6; t++) run_case(tbl[t]);

        // Reset mid-measurement, after the third falling edge
        pulse_start(0);
        send_bits(0, 40, 5, 40);
        check("busy_before_reset", int'(busy), 1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0; rx = 1'b1;
        @(negedge clock);
        check("midrst_busy", int'(busy), 0);
        check("midrst_baud_sel", int'(baud_sel), 0);
        check("midrst_meas_div", int'(meas_div), 0);
        check("midrst_ok", int'(ok), 0);
        repeat (10) @(negedge clock);
        run_case('{8, 2, 1, 15});

        // Narrow instance: one good run, then a timeout with extra starts
        pulse_start(1);
        send_bits(1, 8, 9, 30);
        @(posedge clock); #1 rx2 = 1'b1;
        repeat (3) @(negedge clock);
        check("t2_done_count", d2_seen, 1);
        check("t2_latency", d2_cyc - last_e5, 19);
        check("t2_meas_div", d2_meas, 2);
        check("t2_ok", d2_ok, 1);
        check("t2_baud_sel", int'(baud_sel2), 15);

        pulse_start(1);
        send_bits(1, 8, 1, 1);
        repeat (100) @(posedge clock);
        pulse_start(1);
        repeat (1000) @(posedge clock);
        pulse_start(1);
        for (int k = 0; k < 6000 && d2_seen < 2; k++) @(negedge clock);
        check("tmo_done_count", d2_seen, 2);
        check("tmo_latency", d2_cyc - last_e1, 4099);
        check("tmo_busy_at_done", d2_busy, 1);
        check("tmo_ok", d2_ok, 0);
        check("tmo_meas_div", d2_meas, 2);
        @(negedge clock);
        check("tmo_busy_after", int'(busy2), 0);
        check("tmo_baud_sel", int'(baud_sel2), 15);
        check("tmo_ok_held", int'(ok2), 0);
        rx2 = 1'b1;
        repeat (5) @(negedge clock);
        check("tmo_single_done", d2_seen, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
